clic_gateway: RTL and testbench

Per-source interrupt gateway sitting between the raw interrupt lines and the CLIC register file/arbiter. It supports all four CLIC trigger modes and holds the architectural pending bit. Edge-triggered pending is cleared on claim. Pending changes are written back to the `clicint` register file through a `d`/`de` pair. `intctl` is delivered with its unimplemented low bits forced to 1.

---
 rtl/clic_gateway.sv | 91 +++++++++
 tb/tb_clic_gateway.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clic_gateway.sv
// Per-source CLIC interrupt gateway: trigger-mode handling, architectural pending bit,
// pending write-back to the clicint register file, and clicintctl low-bit masking.
module clic_gateway #(
  parameter int unsigned N_SOURCE   = 32,
  parameter int unsigned INTCTLBITS = 8,
  parameter int unsigned IdWidth    = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_SOURCE-1:0]   intr_src_i,
  input  logic [2*N_SOURCE-1:0] attr_trig_i,
  input  logic [N_SOURCE-1:0]   ie_i,
  input  logic [8*N_SOURCE-1:0] ctl_i,
  input  logic [N_SOURCE-1:0]   ip_sw_q_i,
  input  logic [N_SOURCE-1:0]   ip_sw_qe_i,
  input  logic                  claim_valid_i,
  input  logic [IdWidth-1:0]    claim_id_i,
  output logic [N_SOURCE-1:0]   ip_o,
  output logic [N_SOURCE-1:0]   irq_o,
  output logic [8*N_SOURCE-1:0] intctl_o,
  output logic [N_SOURCE-1:0]   ip_hw_d_o,
  output logic [N_SOURCE-1:0]   ip_hw_de_o
);

  // Unimplemented clicintctl bits read as 1.
  localparam int unsigned MaskInt = (1 << (8 - INTCTLBITS)) - 1;
  localparam logic [7:0]  CtlMask = 8'(MaskInt);

  logic [N_SOURCE-1:0] ip_q, ip_d;
  logic [N_SOURCE-1:0] lvl_q, lvl;
  logic [N_SOURCE-1:0] edge_det;
  logic [N_SOURCE-1:0] edge_mode;
  logic [N_SOURCE-1:0] claim_hit;
  logic                armed_q;

  // Ids at or above N_SOURCE never compare equal to any index.
  always_comb begin
    lvl       = '0;
    edge_mode = '0;
    claim_hit = '0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      lvl[i]       = intr_src_i[i] ^ attr_trig_i[2*i+1];
      edge_mode[i] = attr_trig_i[2*i];
      claim_hit[i] = claim_valid_i && (claim_id_i == IdWidth'(i));
    end
  end

  // armed_q suppresses a spurious edge from lvl_q's reset value.
  assign edge_det = {N_SOURCE{armed_q}} & lvl & ~lvl_q;

  always_comb begin
    ip_d = ip_q;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      if (!edge_mode[i]) begin
        ip_d[i] = lvl[i];
      end else if (edge_det[i]) begin
        ip_d[i] = 1'b1;
      end else if (ip_sw_qe_i[i]) begin
        ip_d[i] = ip_sw_q_i[i];
      end else if (claim_hit[i]) begin
        ip_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ip_q    <= '0;
      lvl_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      ip_q    <= ip_d;
      lvl_q   <= lvl;
      armed_q <= 1'b1;
    end
  end

  assign ip_o      = ip_q;
  assign irq_o     = ip_q & ie_i;
  assign ip_hw_d_o = ip_d;
  // de on every software write so the register file keeps the gateway's view in level mode.
  assign ip_hw_de_o = rst_ni ? ((ip_d ^ ip_q) | ip_sw_qe_i) : '0;

  always_comb begin
    intctl_o = '0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      intctl_o[8*i +: 8] = ctl_i[8*i +: 8] | CtlMask;
    end
  end

endmodule

// File: tb/tb_clic_gateway.sv
// Randomized self-checking bench for clic_gateway against a per-cycle behavioural model,
// plus directed trigger-mode, claim, software-write and mask scenarios.
module tb_clic_gateway;

  localparam int N  = 37;
  localparam int IB = 3;
  localparam int IW = $clog2(N);

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   src;
  logic [2*N-1:0] trig;
  logic [N-1:0]   ie;
  logic [8*N-1:0] ctl;
  logic [N-1:0]   sw_q;
  logic [N-1:0]   sw_qe;
  logic           claim_valid;
  logic [IW-1:0]  claim_id;
  logic [N-1:0]   ip_o, irq_o, hw_d, hw_de;
  logic [8*N-1:0] intctl_o;

  // Small side instances for the mask extremes.
  logic [1:0]  a_zero2;
  logic [3:0]  a_zero4;
  logic [15:0] a_ctl;
  logic        a_zero1;
  logic [1:0]  a0_ip, a0_irq, a0_d, a0_de, a8_ip, a8_irq, a8_d, a8_de;
  logic [15:0] a0_intctl, a8_intctl;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] m_ip, m_prev;
  logic         m_armed;
  logic [N-1:0] last_d, last_de;

  clic_gateway #(.N_SOURCE(N), .INTCTLBITS(IB)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .intr_src_i    (src),
    .attr_trig_i   (trig),
    .ie_i          (ie),
    .ctl_i         (ctl),
    .ip_sw_q_i     (sw_q),
    .ip_sw_qe_i    (sw_qe),
    .claim_valid_i (claim_valid),
    .claim_id_i    (claim_id),
    .ip_o          (ip_o),
    .irq_o         (irq_o),
    .intctl_o      (intctl_o),
    .ip_hw_d_o     (hw_d),
    .ip_hw_de_o    (hw_de)
  );

  clic_gateway #(.N_SOURCE(2), .INTCTLBITS(0)) dut_ib0 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .intr_src_i    (a_zero2),
    .attr_trig_i   (a_zero4),
    .ie_i          (a_zero2),
    .ctl_i         (a_ctl),
    .ip_sw_q_i     (a_zero2),
    .ip_sw_qe_i    (a_zero2),
    .claim_valid_i (a_zero1),
    .claim_id_i    (a_zero1),
    .ip_o          (a0_ip),
    .irq_o         (a0_irq),
    .intctl_o      (a0_intctl),
    .ip_hw_d_o     (a0_d),
    .ip_hw_de_o    (a0_de)
  );

  clic_gateway #(.N_SOURCE(2), .INTCTLBITS(8)) dut_ib8 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .intr_src_i    (a_zero2),
    .attr_trig_i   (a_zero4),
    .ie_i          (a_zero2),
    .ctl_i         (a_ctl),
    .ip_sw_q_i     (a_zero2),
    .ip_sw_qe_i    (a_zero2),
    .claim_valid_i (a_zero1),
    .claim_id_i    (a_zero1),
    .ip_o          (a8_ip),
    .irq_o         (a8_irq),
    .intctl_o      (a8_intctl),
    .ip_hw_d_o     (a8_d),
    .ip_hw_de_o    (a8_de)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] rbits(input int den);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, den - 1) == 0);
    return v;
  endfunction

  // Inputs are stable from posedge+1; comb outputs are checked at the negedge,
  // registered pending just after the following posedge.
  task automatic cycle();
    logic [N-1:0]   nxt, de_exp, lvl;
    logic [8*N-1:0] ctl_exp;
    logic [7:0]     mask;
    bit             is_edge, hit;
    #4;
    mask = 8'hFF >> IB;
    for (int i = 0; i < N; i++) begin
      lvl[i]  = src[i] ^ trig[2*i+1];
      is_edge = m_armed && lvl[i] && !m_prev[i];
      hit     = claim_valid && (int'(claim_id) == i);
      if (!trig[2*i])        nxt[i] = lvl[i];
      else if (is_edge)      nxt[i] = 1'b1;
      else if (sw_qe[i])     nxt[i] = sw_q[i];
      else if (hit)          nxt[i] = 1'b0;
      else                   nxt[i] = m_ip[i];
      de_exp[i] = rst_n && ((nxt[i] != m_ip[i]) || sw_qe[i]);
      ctl_exp[8*i +: 8] = ctl[8*i +: 8] | mask;
    end
    last_d  = hw_d;
    last_de = hw_de;
    check("irq", irq_o, m_ip & ie);
    check("ip_hw_de", hw_de, de_exp);
    if (rst_n) check("ip_hw_d", hw_d, nxt);
    check("intctl", intctl_o, ctl_exp);
    if (!rst_n) begin
      m_ip = '0; m_prev = '0; m_armed = 1'b0;
    end else begin
      m_ip = nxt; m_prev = lvl; m_armed = 1'b1;
    end
    @(posedge clk);
    #1;
    check("ip_o", ip_o, m_ip);
  endtask

  task automatic set_trig(input int i, input logic [1:0] t);
    trig[2*i +: 2] = t;
  endtask

  task automatic idle();
    sw_qe = '0; sw_q = '0; claim_valid = 1'b0; claim_id = '0;
  endtask

  initial begin
    rst_n = 1'b0; src = '0; trig = '0; ie = '1; ctl = '0; idle();
    a_zero1 = 1'b0; a_zero2 = '0; a_zero4 = '0; a_ctl = 16'h0000;
    m_ip = '0; m_prev = '0; m_armed = 1'b0;
    @(posedge clk);
    #1;
    check("reset_ip", ip_o, '0);
    check("reset_irq", irq_o, '0);

    // Rising edge on source 0 held high through reset.
    src[0] = 1'b1; set_trig(0, 2'b01);
    cycle(); cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    check("s1_no_pend", ip_o[0], 1'b0);
    src[0] = 1'b0; cycle();
    src[0] = 1'b1; cycle();
    check("s1_de", last_de[0], 1'b1);
    check("s1_d", last_d[0], 1'b1);
    check("s1_ip", ip_o[0], 1'b1);
    claim_valid = 1'b1; claim_id = 0; cycle(); idle();
    check("s1_claim", ip_o[0], 1'b0);

    // Level-high source 5; claim and software write are ignored.
    set_trig(5, 2'b00); src[5] = 1'b1; cycle();
    check("s2_ip_a", ip_o[5], 1'b1);
    claim_valid = 1'b1; claim_id = 5; sw_qe[5] = 1'b1; sw_q[5] = 1'b0; cycle(); idle();
    check("s2_wr_de", last_de[5], 1'b1);
    check("s2_wr_d", last_d[5], 1'b1);
    check("s2_ip_b", ip_o[5], 1'b1);
    cycle();
    src[5] = 1'b0; cycle();
    check("s2_ip_low", ip_o[5], 1'b0);

    // Falling-edge source 3; out-of-range claim id is ignored.
    set_trig(3, 2'b11); src[3] = 1'b1; cycle();
    src[3] = 1'b0; cycle();
    check("s3_ip_set", ip_o[3], 1'b1);
    claim_valid = 1'b1; claim_id = IW'(N); cycle();
    check("s3_bad_id", ip_o[3], 1'b1);
    claim_id = 3; cycle(); idle();
    check("s3_claim", ip_o[3], 1'b0);

    // Edge with simultaneous claim, then software writes on source 0.
    src[0] = 1'b0; cycle();
    src[0] = 1'b1; claim_valid = 1'b1; claim_id = 0; cycle(); idle();
    check("s4_edge_claim", ip_o[0], 1'b1);
    claim_valid = 1'b1; claim_id = 0; cycle(); idle();
    sw_qe[0] = 1'b1; sw_q[0] = 1'b1; cycle(); idle();
    check("s4_sw_set", ip_o[0], 1'b1);
    sw_qe[0] = 1'b1; sw_q[0] = 1'b0; cycle(); idle();
    check("s4_sw_clr", ip_o[0], 1'b0);
    src[0] = 1'b0; cycle();
    src[0] = 1'b1; sw_qe[0] = 1'b1; sw_q[0] = 1'b0; cycle(); idle();
    check("s4_edge_sw0", ip_o[0], 1'b1);

    // ie toggling each cycle against a pending source 0.
    for (int k = 0; k < 4; k++) begin
      ie = ~ie; cycle();
      check("s5_irq0", irq_o[0], ie[0]);
    end

    // Mask extremes.
    ctl = {N{8'hA0}}; a_ctl = 16'h5AA0; cycle();
    check("mask_ib3", intctl_o[7:0], 8'hBF);
    check("mask_ib0", a0_intctl, 16'hFFFF);
    check("mask_ib8", a8_intctl, 16'h5AA0);

    // Random regression with resets mid-stream.
    for (int c = 0; c < 3000; c++) begin
      src   = src ^ rbits(4);
      if ($urandom_range(0, 7) == 0) trig = {$urandom(), $urandom(), $urandom()};
      ie    = rbits(2);
      for (int i = 0; i < N; i++) ctl[8*i +: 8] = 8'($urandom());
      sw_qe = rbits(10);
      sw_q  = rbits(2);
      claim_valid = $urandom_range(0, 1) == 1;
      claim_id    = IW'($urandom_range(0, (1 << IW) - 1));
      if (!rst_n) rst_n = $urandom_range(0, 2) == 0;
      else        rst_n = $urandom_range(0, 99) != 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
